regfile_wr_arbiter: RTL
=======================

# regfile_wr_arbiter

Round-robin write arbiter and storage for a 4-entry register bank shared by four requesters. Each cycle it grants at most one pending write, registers the winner's address and data, and drives a one-hot decoded write enable into the bank. It returns a one-cycle grant pulse to the winning requester and provides a combinational read port. It sits between the requester agents and the 2-bit address decode / register-bank datapath, and sequences all bank writes.

## Interface
Parameters:
- DATA_W, 8, width of each bank entry and of each requester's write data.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  reset; asynchronous assert, active-low.
- i_req  in  4  write request, bit k = requester k; level, held until granted.
- i_addr  in  8  requester k target entry at [2k+1:2k].
- i_data  in  4*DATA_W  requester k write data at [k*DATA_W +: DATA_W].
- o_gnt  out  4  one-hot grant pulse, high for exactly the cycle its write is applied.
- o_we  out  1  registered bank write enable.
- o_addr  out  2  registered write address of the current write.
- o_decoder  out  4  one-hot decode of o_addr, gated by o_we; 4'b0000 when o_we=0.
- o_busy  out  1  high while in WRITE state.
- i_rd_addr  in  2  read address.
- o_rd_data  out  DATA_W  combinational read of bank[i_rd_addr].

## Operation
- States: IDLE (o_we=0) and WRITE (o_we=1, exactly one o_gnt bit high).
- Eligible set = i_req & ~o_gnt. The requester granted in the current cycle is masked, so a req still high during its own grant cycle is not granted twice.
- IDLE -> WRITE when the eligible set is non-zero. WRITE -> WRITE when non-zero. WRITE -> IDLE when zero.
- Round-robin: search starts at pointer ptr[1:0] and runs ptr, ptr+1, ... mod 4. The first eligible requester wins. On a grant, ptr <= winner+1 (mod 4, wraps 3->0). ptr holds when nothing is granted.
- At the arbitration edge, register the following:
  - o_addr <= winner's i_addr slice.
  - wdata <= winner's i_data slice.
  - o_gnt <= onehot(winner).
  - o_we <= 1.
- Bank write: at the rising edge ending a cycle with o_we=1, bank[o_addr] <= wdata.
- o_decoder = o_we ? (4'b0001 << o_addr) : 4'b0000.
- Same-address writes from different requesters are serialized in round-robin order; the last one applied wins.
- Requester protocol: present addr/data with req, hold them until the o_gnt bit is seen, then drop req or present the next write. A requester holding req continuously gets at most one write every 2 cycles. Aggregate throughput is 1 write/cycle.
- Reset (asserted at any time, including mid-write):
  - o_gnt=0, o_we=0, o_addr=0, o_decoder=0, o_busy=0.
  - ptr=0, wdata=0, all bank entries=0, state IDLE.
  - A pending or in-flight write is dropped, with no grant issued.

## Timing
- Latency: req sampled at edge E. o_gnt/o_we/o_decoder are high in the cycle after E. The bank is updated at edge E+1.
- o_rd_data reflects a write from the cycle after the o_we cycle. There is no write-through bypass: reading the address being written during the o_we cycle returns the old value.
- All outputs except o_decoder and o_rd_data come directly from flops. o_decoder is a decode of flops.
- Reset deassertion must be synchronous to i_clk externally. The first arbitration happens at the first rising edge after deassertion.

## Test plan
- Single write: after reset, set i_req=4'b0100 with addr 2'b11 and data 8'hA5. The next cycle must show o_gnt=4'b0100, o_we=1, o_addr=3, o_decoder=4'b1000. Drop req. bank[3] then reads 8'hA5, and the following cycle returns to IDLE with o_decoder=0.
- Full contention: all four req high continuously, each with a distinct addr and data. Grants must be 0001, 0010, 0100, 1000, 0001, … back-to-back with no idle cycle. Every o_decoder value matches the granted requester's address.
- Fairness and wrap: ptr=3 after granting requester 2, with requesters 0 and 3 requesting. Requester 3 must be granted first, then requester 0.
- Same-address collision: requesters 1 and 2 both target entry 0, with data 8'h11 and 8'h22, with ptr=0. Requester 1 must win first and requester 2 second, leaving bank[0]=8'h22.
- Held request: requester 0 alone holds req high for 6 cycles. o_gnt[0] must pulse every other cycle (3 writes), and no grant may appear in two consecutive cycles.
- Reset mid-operation: assert i_rst_n=0 asynchronously while o_we=1. All outputs must go to 0 immediately, the bank must read 0 at every address, and no grant may occur until req is sampled after deassertion.

Source files
------------

// File: rtl/regfile_wr_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wr_arbiter
//   Round-robin write arbiter in front of a 4-entry register bank shared by
//   four requesters. At most one pending write is granted per cycle. The
//   winner's address and data are registered, and the bank is written one
//   edge later while o_we is high. A combinational read port is provided.
//
// Ports
//   i_clk      clock, rising edge
//   i_rst_n    asynchronous active-low reset
//   i_req      per-requester write request (level, held until granted)
//   i_addr     requester k target entry at [2k+1:2k]
//   i_data     requester k write data at [k*DATA_W +: DATA_W]
//   o_gnt      one-hot grant pulse, high during the cycle its write is applied
//   o_we       registered bank write enable
//   o_addr     registered write address
//   o_decoder  one-hot decode of o_addr, zero when o_we is low
//   o_busy     high while in the WRITE state
//   i_rd_addr  read address
//   o_rd_data  combinational read of bank[i_rd_addr] (no write-through)
// ---------------------------------------------------------------------------
module regfile_wr_arbiter #(
    parameter int DATA_W = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [3:0]            i_req,
    input  logic [7:0]            i_addr,
    input  logic [4*DATA_W-1:0]   i_data,
    output logic [3:0]            o_gnt,
    output logic                  o_we,
    output logic [1:0]            o_addr,
    output logic [3:0]            o_decoder,
    output logic                  o_busy,
    input  logic [1:0]            i_rd_addr,
    output logic [DATA_W-1:0]     o_rd_data
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_WRITE = 1'b1
    } state_t;

    state_t              state_q;
    logic [3:0]          gnt_q;
    logic                we_q;
    logic [1:0]          addr_q;
    logic                busy_q;
    logic [1:0]          ptr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   bank_q [4];

    // Per-requester views of the packed address/data buses.
    logic [1:0]          req_addr [4];
    logic [DATA_W-1:0]   req_data [4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_split
            assign req_addr[gi] = i_addr[2*gi +: 2];
            assign req_data[gi] = i_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // The requester holding the current grant is masked so a request that is
    // still high during its own grant cycle is not serviced twice.
    logic [3:0] eligible;
    logic       found_d;
    logic [1:0] winner_d;

    assign eligible = i_req & ~gnt_q;

    always_comb begin
        found_d  = 1'b0;
        winner_d = 2'd0;
        for (int k = 0; k < 4; k++) begin
            logic [1:0] idx;
            idx = ptr_q + 2'(k);
            if (!found_d && eligible[idx]) begin
                found_d  = 1'b1;
                winner_d = idx;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            gnt_q   <= 4'b0000;
            we_q    <= 1'b0;
            addr_q  <= 2'd0;
            busy_q  <= 1'b0;
            ptr_q   <= 2'd0;
            wdata_q <= '0;
            for (int k = 0; k < 4; k++) begin
                bank_q[k] <= '0;
            end
        end else begin
            // Commit the write registered at the previous edge.
            if (we_q) begin
                bank_q[addr_q] <= wdata_q;
            end

            if (found_d) begin
                state_q <= S_WRITE;
                gnt_q   <= 4'b0001 << winner_d;
                we_q    <= 1'b1;
                busy_q  <= 1'b1;
                addr_q  <= req_addr[winner_d];
                wdata_q <= req_data[winner_d];
                ptr_q   <= winner_d + 2'd1;
            end else begin
                state_q <= S_IDLE;
                gnt_q   <= 4'b0000;
                we_q    <= 1'b0;
                busy_q  <= 1'b0;
            end
        end
    end

    assign o_gnt     = gnt_q;
    assign o_we      = we_q;
    assign o_addr    = addr_q;
    assign o_busy    = busy_q;
    assign o_decoder = we_q ? (4'b0001 << addr_q) : 4'b0000;
    assign o_rd_data = bank_q[i_rd_addr];

endmodule
